// File: rtl/taxi_wait_meter_pkg.sv
// Shared types and helpers for the taxi fare datapath: FSM state encoding and
// two-digit BCD conversions used by the waiting-time meter.
package taxi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SAT  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic int bcd2_to_int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/taxi_wait_meter_if.sv
// Minute-divider / trip-control bundle seen by the waiting meter; master drives
// trip control and the minute pulse, slave is the meter.
interface taxi_wait_meter_if #(
  parameter int FEE_W = 12
);
  logic             trip_start;
  logic             trip_end;
  logic             moving;
  logic             min_pulse;
  logic             div_en;
  logic             div_max;
  logic [7:0]       wait_min;
  logic [FEE_W-1:0] wait_fee;
  logic             fee_tick;
  logic             busy;

  modport master (
    output trip_start, trip_end, moving, min_pulse,
    input  div_en, div_max, wait_min, wait_fee, fee_tick, busy
  );

  modport slave (
    input  trip_start, trip_end, moving, min_pulse,
    output div_en, div_max, wait_min, wait_fee, fee_tick, busy
  );
endinterface

// File: rtl/taxi_wait_meter_bcd2.sv
// Two-digit BCD up-counter with synchronous clear; increments stop at sat_val.
// Count updates one edge after inc is sampled; at_sat decodes the count register.
module bcd2_counter
  import taxi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [7:0] i_sat_val,
  output logic [7:0] o_count,
  output logic       o_at_sat
);

  logic [3:0] r_ones;
  logic [3:0] r_tens;

  assign o_count  = {r_tens, r_ones};
  assign o_at_sat = (o_count == i_sat_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (i_clr) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (i_inc && !o_at_sat) begin
      if (r_ones == BCD_DIGIT_MAX) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/taxi_wait_meter.sv
// Waiting-time meter: enables the minute divider while stopped on a trip, counts
// BCD waiting minutes and accrues the fee past the free allowance; all outputs registered.
module taxi_wait_meter
  import taxi_pkg::*;
#(
  parameter int MAX_MIN     = 99,
  parameter int FREE_MIN    = 3,
  parameter int FEE_PER_MIN = 10,
  parameter int FEE_W       = 12
) (
  input  logic                clk,
  input  logic                rst,
  taxi_wait_meter_if.slave    bus
);

  localparam logic [7:0]       SAT_BCD = int_to_bcd2(MAX_MIN);
  localparam logic [FEE_W-1:0] FEE_MAX = {FEE_W{1'b1}};
  localparam logic [FEE_W:0]   FEE_INC = (FEE_W + 1)'(FEE_PER_MIN);

  state_t           r_state;
  logic [FEE_W-1:0] r_fee;
  logic             r_fee_tick;

  logic [7:0]       w_min;
  logic             w_at_sat;
  logic             w_counted;
  logic             w_charge;
  logic             w_hit_max;
  logic             w_clr;
  logic [FEE_W:0]   w_fee_sum;
  int               w_min_int;

  // Decisions use the pre-increment count: new value > FREE_MIN <=> old >= FREE_MIN.
  assign w_counted = bus.min_pulse && (r_state == ST_WAIT);
  assign w_min_int = bcd2_to_int(w_min);
  assign w_charge  = w_counted && (w_min_int >= FREE_MIN);
  assign w_hit_max = w_counted && (w_min_int == MAX_MIN - 1);
  assign w_clr     = (r_state == ST_IDLE) && bus.trip_start;
  assign w_fee_sum = {1'b0, r_fee} + FEE_INC;

  bcd2_counter u_min_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_inc     (w_counted),
    .i_sat_val (SAT_BCD),
    .o_count   (w_min),
    .o_at_sat  (w_at_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fee      <= '0;
      r_fee_tick <= 1'b0;
    end else begin
      r_fee_tick <= w_charge;
      if (w_charge) begin
        r_fee <= w_fee_sum[FEE_W] ? FEE_MAX : w_fee_sum[FEE_W-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.trip_start) begin
            r_state <= bus.moving ? ST_RUN : ST_WAIT;
            r_fee   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.trip_end)    r_state <= ST_IDLE;
          else if (!bus.moving) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.trip_end)    r_state <= ST_IDLE;
          else if (w_hit_max)  r_state <= ST_SAT;
          else if (bus.moving) r_state <= ST_RUN;
        end
        default: begin
          if (bus.trip_end) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wait_min = w_min;
  assign bus.wait_fee = r_fee;
  assign bus.fee_tick = r_fee_tick;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.div_en   = (r_state == ST_WAIT) || (r_state == ST_SAT);
  assign bus.div_max  = (r_state == ST_SAT) && w_at_sat;

endmodule

// File: tb/tb_taxi_wait_meter.sv
// Bench for taxi_wait_meter: two instances (FEE_W=12 and FEE_W=6) share stimulus;
// a reference model pushes expected outputs per edge, popped and compared after the edge.
module tb_taxi_wait_meter;
  import taxi_pkg::*;

  localparam int MAX_MIN     = 99;
  localparam int FREE_MIN    = 3;
  localparam int FEE_PER_MIN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_wait_meter_if #(.FEE_W(12)) u_if ();
  taxi_wait_meter_if #(.FEE_W(6))  u_if_s ();

  assign u_if_s.trip_start = u_if.trip_start;
  assign u_if_s.trip_end   = u_if.trip_end;
  assign u_if_s.moving     = u_if.moving;
  assign u_if_s.min_pulse  = u_if.min_pulse;

  taxi_wait_meter #(.MAX_MIN(MAX_MIN), .FREE_MIN(FREE_MIN), .FEE_PER_MIN(FEE_PER_MIN), .FEE_W(12))
    u_dut (.clk(clk), .rst(rst), .bus(u_if));
  taxi_wait_meter #(.MAX_MIN(MAX_MIN), .FREE_MIN(FREE_MIN), .FEE_PER_MIN(FEE_PER_MIN), .FEE_W(6))
    u_dut_s (.clk(clk), .rst(rst), .bus(u_if_s));

  typedef struct {
    logic [7:0] wmin;
    int         fee;
    int         fee_s;
    logic       tick;
    logic       busy;
    logic       den;
    logic       dmax;
  } exp_t;

  exp_t sb_q[$];

  int   m_state, m_min, m_fee, m_fee_s;
  logic m_tick;
  logic mv_lvl;
  int   checks, failures, tick_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_min = 0; m_fee = 0; m_fee_s = 0; m_tick = 1'b0;
    sb_q.delete();
  endtask

  // Reference behaviour at one rising edge; states 0=IDLE 1=RUN 2=WAIT 3=SAT.
  task automatic model_step(input logic ts, input logic te, input logic mv, input logic mp);
    int nxt;
    nxt    = m_state;
    m_tick = 1'b0;
    case (m_state)
      0: if (ts) begin m_min = 0; m_fee = 0; m_fee_s = 0; nxt = mv ? 1 : 2; end
      1: if (te) nxt = 0; else if (!mv) nxt = 2;
      2: begin
        if (mp) begin
          m_min = m_min + 1;
          if (m_min > FREE_MIN) begin
            m_tick  = 1'b1;
            m_fee   = (m_fee + FEE_PER_MIN > 4095) ? 4095 : m_fee + FEE_PER_MIN;
            m_fee_s = (m_fee_s + FEE_PER_MIN > 63) ? 63 : m_fee_s + FEE_PER_MIN;
          end
        end
        if (te) nxt = 0;
        else if (mp && m_min == MAX_MIN) nxt = 3;
        else if (mv) nxt = 1;
      end
      default: if (te) nxt = 0;
    endcase
    m_state = nxt;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.wmin  = {4'(m_min / 10), 4'(m_min % 10)};
    e.fee   = m_fee;
    e.fee_s = m_fee_s;
    e.tick  = m_tick;
    e.busy  = (m_state != 0);
    e.den   = (m_state >= 2);
    e.dmax  = (m_state == 3);
    return e;
  endfunction

  task automatic cmp_all(input exp_t e);
    chk_eq("wait_min", u_if.wait_min, e.wmin);
    chk_eq("wait_fee", u_if.wait_fee, e.fee);
    chk_eq("wait_fee_w6", u_if_s.wait_fee, e.fee_s);
    chk_eq("fee_tick", u_if.fee_tick, e.tick);
    chk_eq("fee_tick_w6", u_if_s.fee_tick, e.tick);
    chk_eq("busy", u_if.busy, e.busy);
    chk_eq("div_en", u_if.div_en, e.den);
    chk_eq("div_max", u_if.div_max, e.dmax);
  endtask

  // Called just after a rising edge: drive, predict, clock, compare.
  task automatic cyc(input logic ts, input logic te, input logic mp);
    exp_t e;
    u_if.trip_start = ts;
    u_if.trip_end   = te;
    u_if.moving     = mv_lvl;
    u_if.min_pulse  = mp;
    model_step(ts, te, mv_lvl, mp);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    u_if.trip_start = 1'b0;
    u_if.trip_end   = 1'b0;
    u_if.min_pulse  = 1'b0;
    if (sb_q.size() == 0) begin
      chk_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      cmp_all(e);
    end
    if (u_if.fee_tick) tick_cnt++;
  endtask

  task automatic pulse();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; tick_cnt = 0;
    mv_lvl = 1'b0;
    u_if.trip_start = 1'b0;
    u_if.trip_end   = 1'b0;
    u_if.moving     = 1'b0;
    u_if.min_pulse  = 1'b0;
    model_reset();

    #12;
    chk_eq("rst_wait_min", u_if.wait_min, 8'h00);
    chk_eq("rst_wait_fee", u_if.wait_fee, 0);
    chk_eq("rst_busy", u_if.busy, 1'b0);
    chk_eq("rst_div_en", u_if.div_en, 1'b0);
    chk_eq("rst_div_max", u_if.div_max, 1'b0);
    chk_eq("rst_fee_tick", u_if.fee_tick, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stopped trip: five minutes, last two charged.
    cyc(1'b1, 1'b0, 1'b0);
    chk_eq("start_busy", u_if.busy, 1'b1);
    chk_eq("start_div_en", u_if.div_en, 1'b1);
    tick_cnt = 0;
    repeat (5) pulse();
    chk_eq("five_min", u_if.wait_min, 8'h05);
    chk_eq("five_fee", u_if.wait_fee, 20);
    chk_eq("five_ticks", tick_cnt, 2);

    // Moving: pulses discarded; a trip_start while active is ignored.
    mv_lvl = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) pulse();
    cyc(1'b1, 1'b0, 1'b0);
    chk_eq("run_div_en", u_if.div_en, 1'b0);
    chk_eq("run_min_hold", u_if.wait_min, 8'h05);
    mv_lvl = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Count up to saturation, checking the 09->10 carry on the way.
    for (int i = 0; i < 100; i++) begin
      pulse();
      if (m_min == 10 && i == 4) chk_eq("carry_10", u_if.wait_min, 8'h10);
    end
    chk_eq("sat_min", u_if.wait_min, 8'h99);
    chk_eq("sat_div_max", u_if.div_max, 1'b1);
    chk_eq("sat_fee", u_if.wait_fee, 960);
    chk_eq("sat_fee_w6", u_if_s.wait_fee, 63);
    mv_lvl = 1'b1;
    repeat (3) pulse();
    chk_eq("sat_stays", u_if.div_max, 1'b1);
    mv_lvl = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    chk_eq("end_hold_min", u_if.wait_min, 8'h99);

    // New trip clears; trip_end coincident with a minute still counts it.
    cyc(1'b1, 1'b0, 1'b0);
    chk_eq("clr_min", u_if.wait_min, 8'h00);
    repeat (2) pulse();
    cyc(1'b0, 1'b1, 1'b1);
    chk_eq("end_cnt_min", u_if.wait_min, 8'h03);
    chk_eq("end_idle", u_if.busy, 1'b0);
    pulse();
    cyc(1'b0, 1'b1, 1'b0);

    // Start while moving, then a minute coincident with moving going high.
    mv_lvl = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (2) pulse();
    mv_lvl = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    repeat (4) pulse();
    mv_lvl = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    chk_eq("mv_edge_min", u_if.wait_min, 8'h05);
    chk_eq("mv_edge_run", u_if.div_en, 1'b0);
    mv_lvl = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    pulse();

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_wait_min", u_if.wait_min, 8'h00);
    chk_eq("arst_wait_fee", u_if.wait_fee, 0);
    chk_eq("arst_busy", u_if.busy, 1'b0);
    chk_eq("arst_div_en", u_if.div_en, 1'b0);
    chk_eq("arst_fee_tick", u_if.fee_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b0);
    pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
